// File: rtl/sisc_pkg.sv
// Shared SISC datapath definitions: LSU state encoding and default bus/timeout sizes.
package sisc_pkg;

  localparam int LSU_AW      = 16;
  localparam int LSU_DW      = 32;
  localparam int LSU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/sisc_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and the memory (slave).
interface sisc_lsu_if import sisc_pkg::*; #(
  parameter int AW = LSU_AW,
  parameter int DW = LSU_DW
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/sisc_lsu_timer.sv
// 8-bit clear/increment wait counter; hit flags the last allowed wait cycle.
module lsu_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign hit = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/sisc_lsu.sv
// SISC load/store unit: one req/ack memory transaction per start, with abort timeout.
module sisc_lsu import sisc_pkg::*; #(
  parameter int AW      = LSU_AW,
  parameter int DW      = LSU_DW,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          start,
  input  logic          is_store,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] ld_data,
  sisc_lsu_if.master    mem
);

  lsu_state_e state;
  logic       tmr_clr;
  logic       tmr_inc;
  logic       tmr_hit;

  assign tmr_clr = (state == IDLE) && start;
  assign tmr_inc = (state == BUSY) && !mem.mem_ack;

  lsu_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst_f),
    .clr (tmr_clr),
    .inc (tmr_inc),
    .hit (tmr_hit)
  );

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      ld_data       <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= BUSY;
            busy          <= 1'b1;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= addr;
            mem.mem_wdata <= wdata;
          end
        end
        BUSY: begin
          // An ack on the final counted cycle still completes normally.
          if (mem.mem_ack) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b0;
            if (!mem.mem_we) begin
              ld_data <= mem.mem_rdata;
            end
          end else if (tmr_hit) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_lsu.sv
// Randomized self-checking bench for sisc_lsu against a transaction-level reference model.
module tb_sisc_lsu;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_f;
  logic          start;
  logic          is_store;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] ld_data;

  sisc_lsu_if #(.AW(AW), .DW(DW)) mem ();

  sisc_lsu #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .start    (start),
    .is_store (is_store),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ld_data  (ld_data),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] ld_model = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One LD/ST transaction; ack_cycle is the request cycle carrying mem_ack (0 = never).
  task automatic run_txn(input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ack_cycle, input logic [DW-1:0] rd, input bit restart);
    int  reqs     = 0;
    int  busy_cnt = 0;
    int  done_cyc = 0;
    bit  latch_ok = 1'b1;
    bit  ok_ack;
    int  exp_reqs;
    logic [DW-1:0] exp_ld;

    ok_ack   = (ack_cycle >= 1) && (ack_cycle <= TIMEOUT);
    exp_reqs = ok_ack ? ack_cycle : TIMEOUT;
    exp_ld   = (ok_ack && !st) ? rd : ld_model;

    @(negedge clk);
    start = 1'b1; is_store = st; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0; is_store = $urandom; addr = AW'($urandom); wdata = $urandom;

    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      start = 1'b0;
      if (restart && c == 2) begin
        start = 1'b1; addr = a ^ 16'h5A5A; is_store = ~st;
      end
      if (mem.mem_req) begin
        reqs++;
        if (mem.mem_addr !== a || mem.mem_we !== st || mem.mem_wdata !== d) latch_ok = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        check("err", err, !ok_ack);
        check("ld_data", ld_data, exp_ld);
        break;
      end
      if (mem.mem_req) begin
        mem.mem_ack   = (reqs == ack_cycle);
        mem.mem_rdata = (reqs == ack_cycle) ? rd : $urandom;
      end else begin
        mem.mem_ack   = $urandom;
        mem.mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;

    check("done_cycle", done_cyc, exp_reqs + 1);
    check("req_cycles", reqs, exp_reqs);
    check("busy_cycles", busy_cnt, exp_reqs + 1);
    check("latched_ops", latch_ok, 1'b1);
    ld_model = exp_ld;
    mem.mem_ack = $urandom;
    @(negedge clk);
    check("idle_after", {busy, done, mem.mem_req}, 3'b000);
    mem.mem_ack = 1'b0;
  endtask

  initial begin
    int ac;
    rst_f = 1'b1; start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, err, mem.mem_req, mem.mem_we}, 5'b0);
    check("rst_addr", mem.mem_addr, 16'h0);
    check("rst_wdata", mem.mem_wdata, 32'h0);
    check("rst_ld", ld_data, 32'h0);
    rst_f = 1'b0;

    run_txn(1'b0, 16'h0010, 32'h0, 1, 32'h1234_5678, 1'b0);
    run_txn(1'b1, 16'h00FF, 32'hCAFE_0001, 4, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b0, 16'h0020, 32'h0, 0, 32'hBAD0_BAD0, 1'b0);
    run_txn(1'b0, 16'h0030, 32'h0, TIMEOUT, 32'h0BAD_F00D, 1'b0);
    run_txn(1'b0, 16'h0040, 32'h0, TIMEOUT + 1, 32'h1111_2222, 1'b0);
    run_txn(1'b0, 16'h0050, 32'h0, 5, 32'hA5A5_0050, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ac = $urandom_range(0, TIMEOUT + 2);
      run_txn($urandom, AW'($urandom), $urandom, ac, $urandom, (ac == 0 || ac >= 3) && ($urandom_range(0, 3) == 0));
    end

    // Reset during the second wait cycle of a load that never gets acked.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; addr = 16'h0077; wdata = '0;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", mem.mem_req, 1'b1);
    mem.mem_ack = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    check("midrst_req_busy", {mem.mem_req, busy, done}, 3'b000);
    check("midrst_ld", ld_data, 32'h0);
    ld_model = '0;
    begin
      int dones = 0;
      for (int c = 0; c < TIMEOUT + 4; c++) begin
        if (done || busy) dones++;
        @(negedge clk);
      end
      check("midrst_no_done", dones, 0);
    end

    run_txn(1'b0, 16'h0088, 32'h0, 2, 32'h7777_8888, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sisc_lsu.md
# sisc_lsu

Load/store unit for the SISC datapath, sitting directly downstream of the ALU and upstream of the write-back mux. It takes the ALU result as a data-memory address and the RF `rsb` value as store data, runs a single request/acknowledge transaction against a variable-latency data memory, and returns load data to the write-back mux (the mux32 second input). The control unit holds off the next instruction while `busy` is high. An abort timeout reports a hung memory instead of stalling the processor forever.

## Interface
- `AW`, 16: data-memory address width, word addressed.
- `DW`, 32: data word width.
- `TIMEOUT`, 15: maximum cycles in BUSY waiting for `mem_ack`, range 2..255.

- `clk`  in  1  processor clock; all state updates on the rising edge.
- `rst_f`  in  1  reset, synchronous, active-high (1 = reset).
- `start`  in  1  one-cycle request from ctrl for a LD/ST instruction.
- `is_store`  in  1  1 = store, 0 = load; sampled with `start`.
- `addr`  in  AW  address, ALU result[AW-1:0]; sampled with `start`.
- `wdata`  in  DW  store data, RF `rsb`; sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the transaction ends.
- `err`  out  1  valid with `done`: 1 = timed out.
- `ld_data`  out  DW  last successful load data, held until the next successful load.
- `mem_req`  out  1  memory request, held until ack or timeout.
- `mem_we`  out  1  write enable, valid while `mem_req` is high.
- `mem_addr`  out  AW  latched address.
- `mem_wdata`  out  DW  latched store data.
- `mem_rdata`  in  DW  load data, valid when `mem_ack` is high.
- `mem_ack`  in  1  memory completion, may be combinational from `mem_req`.

## Operation
- FSM states and outputs:
  - IDLE: `busy`=0, `mem_req`=0.
  - BUSY: `mem_req`=1.
  - DONE: `done`=1, `mem_req`=0.
- IDLE -> BUSY when `start` is sampled high. On that edge:
  - `is_store`, `addr` and `wdata` latch into `mem_we`, `mem_addr` and `mem_wdata`.
  - The timeout counter clears to 0.
- BUSY -> DONE when `mem_ack` is sampled high.
  - For a load, `ld_data` <= `mem_rdata`.
  - `err` = 0.
- BUSY with `mem_ack` low: counter increments.
  - If the counter equals TIMEOUT-1 at that edge, go to DONE with `err` = 1.
  - `ld_data` is unchanged.
- DONE -> IDLE unconditionally after one cycle.
- `start` in BUSY or DONE is ignored; ctrl must not issue while `busy` is high.
- `mem_ack` in IDLE or DONE is ignored.
- `mem_ack` high on the same edge the counter reaches TIMEOUT-1: the ack wins, giving a normal completion with `err` = 0.
- Counter width is 8 bits and cannot wrap, because TIMEOUT is at most 255.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole BUSY period.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `ld_data`=0, counter 0.
- Reset mid-transaction: `mem_req` is low in the cycle after the reset edge, the transaction is dropped, and no `done` is produced.
- Cycle sequence for `start` sampled at edge E0:
  - `mem_req` rises in the cycle after E0.
  - With ack in that same cycle (zero-wait memory), `done` is high in the cycle after edge E1, and `busy` is high for 2 cycles.
  - Each wait cycle adds 1 cycle.
  - A timeout gives `busy` for TIMEOUT+1 cycles.
- `ld_data` is valid from the `done` cycle onward. Write-back uses `ld_data` in the `done` cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_ack` to `mem_req`.

## Structure
- Shared package `sisc_pkg` holds:
  - the LSU state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - the AW and DW defaults;
  - the default TIMEOUT constant.
- One sub-module, `lsu_timer`: the 8-bit clear/increment counter with a `hit` output when count == TIMEOUT-1.
- The FSM and operand latches live in `sisc_lsu`.

## Test plan
- Zero-wait load: memory acks combinationally with `mem_rdata`=32'h1234_5678; `start` with `is_store`=0, `addr`=16'h0010 -> `mem_req` for 1 cycle, `done` 2 cycles after `start`, `ld_data`=32'h1234_5678, `err`=0.
- 3-wait store: `addr`=16'h00FF, `wdata`=32'hCAFE_0001, ack on the 4th request cycle -> `mem_we`=1 and `mem_addr`/`mem_wdata` stable for 4 cycles, `done` with `err`=0, `ld_data` unchanged.
- Timeout, TIMEOUT=15, no ack -> `mem_req` high exactly 15 cycles, `done` with `err`=1, `ld_data` keeps its previous value, FSM returns to IDLE.
- Boundary: ack on the 15th request cycle, the same edge the counter reaches 14 -> normal completion with `err`=0 and load data captured.
- `start` pulsed again during BUSY with a different `addr` -> ignored, and `mem_addr` keeps its first value.
- Reset asserted in the 2nd wait cycle -> `mem_req`=0 and `busy`=0 next cycle, no `done` pulse, `ld_data`=0.
